// File: rtl/evm_display_pkg.sv
// Shared types and constants for the EVM result display scheduler.
package evm_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_BLANK = 4'd15;
    localparam int         NUM_DIGITS  = 4;
    localparam int         BCD_ITERS   = 8;

    // Replace a digit with the blank code when leading-zero blanking applies.
    function automatic logic [3:0] blank_if(input logic blank, input logic [3:0] digit);
        return blank ? DIGIT_BLANK : digit;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter, one iteration per clock.
// A start pulse loads the operand; done is high during the cycle whose edge
// performs the final iteration, so bcd holds the result on the following cycle.
module bin2bcd_seq
    import evm_display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    localparam logic [2:0] LAST_ITER = 3'(BCD_ITERS - 1);

    logic [19:0] shift_q, shift_d;
    logic [19:0] adj;
    logic [2:0]  cnt_q, cnt_d;
    logic        run_q, run_d;

    // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
    always_comb begin
        adj     = shift_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        for (int i = 0; i < 3; i++) begin
            if (shift_q[8 + 4*i +: 4] >= 4'd5) begin
                adj[8 + 4*i +: 4] = shift_q[8 + 4*i +: 4] + 4'd3;
            end
        end
        if (start) begin
            shift_d = {12'd0, bin};
            cnt_d   = 3'd0;
            run_d   = 1'b1;
        end else if (run_q) begin
            shift_d = adj << 1;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == LAST_ITER) begin
                run_d = 1'b0;
            end
        end
    end

    // Datapath and iteration counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

    assign done = run_q && (cnt_q == LAST_ITER);
    assign bcd  = shift_q[19:8];

endmodule

// File: rtl/evm_display_scheduler.sv
// Captures the winner and vote count, converts the count to BCD, applies
// leading-zero blanking and time-multiplexes four digits with active-low anodes.
module evm_display_scheduler
    import evm_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [1:0] winner_id,
    input  logic [7:0] winning_votes,
    output logic [7:0] digit_code,
    output logic [3:0] anode,
    output logic       busy
);

    localparam int            PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        pend_valid_q, pend_valid_d;
    logic [1:0]  pend_id_q, pend_id_d;
    logic [7:0]  pend_votes_q, pend_votes_d;
    logic [1:0]  id_q, id_d;
    logic [3:0]  disp_q [NUM_DIGITS];
    logic [3:0]  disp_d [NUM_DIGITS];
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]  idx_q, idx_d;

    logic        conv_start;
    logic [7:0]  conv_bin;
    logic        conv_done;
    logic [11:0] conv_bcd;
    logic [3:0]  hundreds, tens, ones;

    assign hundreds = conv_bcd[11:8];
    assign tens     = conv_bcd[7:4];
    assign ones     = conv_bcd[3:0];

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (conv_bin),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Next-state logic for the sequencer, the pending slot and the display registers.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        pend_valid_d = pend_valid_q;
        pend_id_d    = pend_id_q;
        pend_votes_d = pend_votes_q;
        id_d         = id_q;
        disp_d       = disp_q;
        conv_start   = 1'b0;
        conv_bin     = winning_votes;
        case (state_q)
            IDLE: begin
                if (load) begin
                    id_d       = winner_id;
                    conv_start = 1'b1;
                    state_d    = CONVERT;
                    busy_d     = 1'b1;
                end
            end
            CONVERT: begin
                if (load) begin
                    pend_valid_d = 1'b1;
                    pend_id_d    = winner_id;
                    pend_votes_d = winning_votes;
                end
                if (conv_done) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                disp_d[3] = {2'b00, id_q} + 4'd1;
                disp_d[2] = blank_if(hundreds == 4'd0, hundreds);
                disp_d[1] = blank_if((hundreds == 4'd0) && (tens == 4'd0), tens);
                disp_d[0] = ones;
                if (load || pend_valid_q) begin
                    // A load arriving now is newer than anything already pending.
                    if (load) begin
                        id_d     = winner_id;
                        conv_bin = winning_votes;
                    end else begin
                        id_d     = pend_id_q;
                        conv_bin = pend_votes_q;
                    end
                    conv_start   = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = CONVERT;
                    busy_d       = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Free-running refresh prescaler and digit index, independent of the sequencer.
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end
    end

    // All state registers with synchronous reset to a blank display.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= '0;
            pend_votes_q <= '0;
            id_q         <= '0;
            presc_q      <= '0;
            idx_q        <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                disp_q[i] <= DIGIT_BLANK;
            end
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            pend_votes_q <= pend_votes_d;
            id_q         <= id_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
        end
    end

    assign digit_code = {4'b0000, disp_q[idx_q]};
    assign anode      = ~(4'b0001 << idx_q);
    assign busy       = busy_q;

endmodule

// File: tb/tb_evm_display_scheduler.sv
// Directed self-checking bench for evm_display_scheduler.
module tb_evm_display_scheduler;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [1:0] winner_id;
    logic [7:0] winning_votes;
    logic [7:0] digit_code, digit_code1;
    logic [3:0] anode, anode1;
    logic       busy, busy1;

    int errors = 0;
    int checks = 0;

    int         mp;
    logic [1:0] mi;
    logic [1:0] mi1;
    logic [3:0] exp_disp [4];

    evm_display_scheduler #(.REFRESH_DIV(DIV)) dut (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .winner_id     (winner_id),
        .winning_votes (winning_votes),
        .digit_code    (digit_code),
        .anode         (anode),
        .busy          (busy)
    );

    evm_display_scheduler #(.REFRESH_DIV(1)) dut1 (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .winner_id     (winner_id),
        .winning_votes (winning_votes),
        .digit_code    (digit_code1),
        .anode         (anode1),
        .busy          (busy1)
    );

    always #5 clk = ~clk;

    // Advance one clock and track the expected scan position of both instances.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            mp  = 0;
            mi  = 2'd0;
            mi1 = 2'd0;
        end else begin
            if (mp == DIV - 1) begin
                mp = 0;
                mi = mi + 2'd1;
            end else begin
                mp = mp + 1;
            end
            mi1 = mi1 + 2'd1;
        end
        #1;
    endtask

    task automatic setExp(input logic [3:0] d3, input logic [3:0] d2,
                          input logic [3:0] d1, input logic [3:0] d0);
        exp_disp[3] = d3;
        exp_disp[2] = d2;
        exp_disp[1] = d1;
        exp_disp[0] = d0;
    endtask

    task automatic checkOutput(input string tag, input logic exp_busy);
        logic [7:0] exp_code;
        logic [3:0] exp_anode;
        exp_code  = {4'b0000, exp_disp[mi]};
        exp_anode = ~(4'b0001 << mi);
        checks++;
        assert (digit_code === exp_code) else begin
            errors++;
            $error("[TB] FAIL %s digit_code got %0d want %0d (idx %0d)", tag, digit_code, exp_code, mi);
        end
        checks++;
        assert (anode === exp_anode) else begin
            errors++;
            $error("[TB] FAIL %s anode got %b want %b", tag, anode, exp_anode);
        end
        checks++;
        assert (busy === exp_busy) else begin
            errors++;
            $error("[TB] FAIL %s busy got %b want %b", tag, busy, exp_busy);
        end
    endtask

    task automatic checkFast(input string tag);
        logic [3:0] exp_anode;
        exp_anode = ~(4'b0001 << mi1);
        checks++;
        assert (anode1 === exp_anode) else begin
            errors++;
            $error("[TB] FAIL %s anode1 got %b want %b", tag, anode1, exp_anode);
        end
        checks++;
        assert (digit_code1 === 8'd15 && busy1 === 1'b0) else begin
            errors++;
            $error("[TB] FAIL %s fast idle got code=%0d busy=%b want code=15 busy=0", tag, digit_code1, busy1);
        end
    endtask

    // Present one load so that it is sampled on the next edge; returns in the cycle after it.
    task automatic applyStimulus(input logic [7:0] votes, input logic [1:0] id);
        load          = 1'b1;
        winning_votes = votes;
        winner_id     = id;
        step();
        load = 1'b0;
    endtask

    // Single load from idle: busy for nine cycles with the old display, then the new digits.
    task automatic runLoad(input string tag, input logic [7:0] votes, input logic [1:0] id,
                           input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0);
        applyStimulus(votes, id);
        for (int c = 1; c <= 9; c++) begin
            checkOutput({tag, "_busy"}, 1'b1);
            step();
        end
        setExp(d3, d2, d1, d0);
        for (int c = 0; c < 16; c++) begin
            checkOutput({tag, "_show"}, 1'b0);
            step();
        end
    endtask

    initial begin
        reset         = 1'b1;
        load          = 1'b0;
        winner_id     = 2'd0;
        winning_votes = 8'd0;
        mp            = 0;
        mi            = 2'd0;
        mi1           = 2'd0;
        setExp(4'd15, 4'd15, 4'd15, 4'd15);

        repeat (3) step();
        reset = 1'b0;
        $display("[TB] reset state and idle scan rotation");
        checks++;
        assert (anode === 4'b1110) else begin
            errors++;
            $error("[TB] FAIL reset_anode got %b want 1110", anode);
        end
        for (int c = 0; c < 16; c++) begin
            checkOutput("reset_scan", 1'b0);
            checkFast("fast_scan");
            step();
        end

        $display("[TB] single loads");
        runLoad("v205", 8'd205, 2'd2, 4'd3, 4'd2, 4'd0, 4'd5);
        runLoad("v7",   8'd7,   2'd0, 4'd1, 4'd15, 4'd15, 4'd7);
        runLoad("v0",   8'd0,   2'd0, 4'd1, 4'd15, 4'd15, 4'd0);
        runLoad("v255", 8'd255, 2'd3, 4'd4, 4'd2, 4'd5, 4'd5);
        runLoad("v40",  8'd40,  2'd1, 4'd2, 4'd15, 4'd4, 4'd0);

        $display("[TB] loads while busy, latest pending wins");
        applyStimulus(8'd100, 2'd1);
        for (int c = 1; c <= 18; c++) begin
            if (c == 10) setExp(4'd2, 4'd1, 4'd0, 4'd0);
            checkOutput("chain", 1'b1);
            if (c == 3) begin
                load = 1'b1; winning_votes = 8'd42; winner_id = 2'd0;
            end else if (c == 5) begin
                load = 1'b1; winning_votes = 8'd99; winner_id = 2'd2;
            end
            step();
            load = 1'b0;
        end
        step();
        setExp(4'd3, 4'd15, 4'd9, 4'd9);
        for (int c = 0; c < 16; c++) begin
            checkOutput("chain_final", 1'b0);
            step();
        end

        $display("[TB] load coincident with update");
        applyStimulus(8'd50, 2'd0);
        for (int c = 1; c <= 18; c++) begin
            if (c == 10) setExp(4'd1, 4'd15, 4'd5, 4'd0);
            checkOutput("coinc", 1'b1);
            if (c == 9) begin
                load = 1'b1; winning_votes = 8'd8; winner_id = 2'd3;
            end
            step();
            load = 1'b0;
        end
        setExp(4'd4, 4'd15, 4'd15, 4'd8);
        for (int c = 0; c < 16; c++) begin
            checkOutput("coinc_final", 1'b0);
            step();
        end

        $display("[TB] reset during conversion");
        applyStimulus(8'd123, 2'd1);
        for (int c = 1; c <= 3; c++) begin
            checkOutput("abort_busy", 1'b1);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        setExp(4'd15, 4'd15, 4'd15, 4'd15);
        checks++;
        assert (anode === 4'b1110) else begin
            errors++;
            $error("[TB] FAIL abort_anode got %b want 1110", anode);
        end
        for (int c = 0; c < 20; c++) begin
            checkOutput("abort_blank", 1'b0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
